// File: rtl/ascon_blk_feeder.sv
// Data-supply side of the ASCON core block handshake: buffers host input blocks,
// answers core data requests, captures ciphertext blocks and the tag, launches runs.
module ascon_blk_feeder #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned IN_DEPTH = 4,
    parameter int unsigned CT_DEPTH = 4,
    parameter int unsigned TAG_W    = 128
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              go_i,
    input  logic              blk_wr_i,
    input  logic [DATA_W-1:0] blk_data_i,
    output logic              in_full_o,
    input  logic              ct_rd_i,
    output logic [DATA_W-1:0] ct_data_o,
    output logic              ct_empty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              tag_ok_o,
    output logic              busy_o,
    output logic [2:0]        err_o,
    input  logic              core_ready_i,
    output logic              core_start_o,
    input  logic              data_req_i,
    output logic              data_valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ct_valid_i,
    input  logic [DATA_W-1:0] ct_i,
    input  logic              tag_valid_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic              done_i
);

    localparam int unsigned IN_AW = $clog2(IN_DEPTH);
    localparam int unsigned CT_AW = $clog2(CT_DEPTH);
    localparam logic [IN_AW:0] IN_CNT_MAX = (IN_AW + 1)'(IN_DEPTH);
    localparam logic [CT_AW:0] CT_CNT_MAX = (CT_AW + 1)'(CT_DEPTH);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StLaunch   = 2'd1;
    localparam logic [1:0] StWaitReq  = 2'd2;
    localparam logic [1:0] StWaitData = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic [DATA_W-1:0] r_in_mem [IN_DEPTH];
    logic [IN_AW-1:0]  r_in_wptr;
    logic [IN_AW-1:0]  r_in_rptr;
    logic [IN_AW:0]    r_in_cnt;
    logic              w_in_empty;
    logic              w_in_full;
    logic              w_in_pop;
    logic              w_in_push;
    logic              w_in_ovf;

    logic [DATA_W-1:0] r_ct_mem [CT_DEPTH];
    logic [CT_AW-1:0]  r_ct_wptr;
    logic [CT_AW-1:0]  r_ct_rptr;
    logic [CT_AW:0]    r_ct_cnt;
    logic              w_ct_empty;
    logic              w_ct_full;
    logic              w_ct_pop;
    logic              w_ct_push;
    logic              w_ct_ovf;

    logic              w_launch;
    logic              w_req_err;
    logic              r_data_valid;
    logic [DATA_W-1:0] r_data;
    logic [2:0]        r_err;
    logic [TAG_W-1:0]  r_tag;
    logic              r_tag_ok;

    assign w_launch   = (r_state == StLaunch);
    assign w_in_empty = (r_in_cnt == '0);
    assign w_in_full  = (r_in_cnt == IN_CNT_MAX);
    // A pop in the same cycle frees a slot, so a push on a full FIFO is still accepted.
    assign w_in_push  = blk_wr_i & (~w_in_full | w_in_pop);
    assign w_in_ovf   = blk_wr_i & w_in_full & ~w_in_pop;

    assign w_ct_empty = (r_ct_cnt == '0);
    assign w_ct_full  = (r_ct_cnt == CT_CNT_MAX);
    assign w_ct_pop   = ct_rd_i & ~w_ct_empty & ~w_launch;
    assign w_ct_push  = ct_valid_i & (~w_ct_full | ct_rd_i) & ~w_launch;
    assign w_ct_ovf   = ct_valid_i & w_ct_full & ~ct_rd_i;

    // Next-state and input-FIFO pop decision for the request handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_in_pop    = 1'b0;
        w_req_err   = 1'b0;
        case (r_state)
            StIdle: begin
                if (go_i && core_ready_i) w_state_nxt = StLaunch;
            end
            StLaunch: begin
                w_state_nxt = StWaitReq;
            end
            StWaitReq: begin
                // Serve the request in its own cycle so valid appears exactly one cycle later.
                if (data_req_i) begin
                    if (!w_in_empty) w_in_pop = 1'b1;
                    else             w_state_nxt = StWaitData;
                end else if (done_i && (r_tag_ok || tag_valid_i)) begin
                    w_state_nxt = StIdle;
                end
            end
            StWaitData: begin
                w_req_err = data_req_i;
                if (!w_in_empty) begin
                    w_in_pop    = 1'b1;
                    w_state_nxt = StWaitReq;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= StIdle;
        else          r_state <= w_state_nxt;
    end

    // Input FIFO storage; contents are only observed through valid pointers.
    always_ff @(posedge clk_i) begin
        if (w_in_push) r_in_mem[r_in_wptr] <= blk_data_i;
    end

    // Input FIFO pointers and occupancy; survives launches so blocks can be preloaded.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_in_wptr <= '0;
            r_in_rptr <= '0;
            r_in_cnt  <= '0;
        end else begin
            if (w_in_push) r_in_wptr <= r_in_wptr + IN_AW'(1);
            if (w_in_pop)  r_in_rptr <= r_in_rptr + IN_AW'(1);
            if (w_in_push && !w_in_pop)      r_in_cnt <= r_in_cnt + (IN_AW + 1)'(1);
            else if (!w_in_push && w_in_pop) r_in_cnt <= r_in_cnt - (IN_AW + 1)'(1);
        end
    end

    // Block handed to the core: valid pulses once per pop, data held until the next pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data_valid <= 1'b0;
            r_data       <= '0;
        end else begin
            r_data_valid <= w_in_pop;
            if (w_in_pop) r_data <= r_in_mem[r_in_rptr];
        end
    end

    // Ciphertext FIFO storage.
    always_ff @(posedge clk_i) begin
        if (w_ct_push) r_ct_mem[r_ct_wptr] <= ct_i;
    end

    // Ciphertext FIFO pointers and occupancy; emptied at each launch.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ct_wptr <= '0;
            r_ct_rptr <= '0;
            r_ct_cnt  <= '0;
        end else if (w_launch) begin
            r_ct_wptr <= '0;
            r_ct_rptr <= '0;
            r_ct_cnt  <= '0;
        end else begin
            if (w_ct_push) r_ct_wptr <= r_ct_wptr + CT_AW'(1);
            if (w_ct_pop)  r_ct_rptr <= r_ct_rptr + CT_AW'(1);
            if (w_ct_push && !w_ct_pop)      r_ct_cnt <= r_ct_cnt + (CT_AW + 1)'(1);
            else if (!w_ct_push && w_ct_pop) r_ct_cnt <= r_ct_cnt - (CT_AW + 1)'(1);
        end
    end

    // Sticky error flags and tag capture, both reset by a launch.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err    <= '0;
            r_tag    <= '0;
            r_tag_ok <= 1'b0;
        end else if (w_launch) begin
            r_err    <= '0;
            r_tag    <= '0;
            r_tag_ok <= 1'b0;
        end else begin
            r_err <= r_err | {w_ct_ovf, w_req_err, w_in_ovf};
            if (tag_valid_i) begin
                r_tag    <= tag_i;
                r_tag_ok <= 1'b1;
            end
        end
    end

    assign in_full_o    = w_in_full;
    // Gate the head so an empty FIFO never exposes stale or unreset storage.
    assign ct_data_o    = w_ct_empty ? '0 : r_ct_mem[r_ct_rptr];
    assign ct_empty_o   = w_ct_empty;
    assign tag_o        = r_tag;
    assign tag_ok_o     = r_tag_ok;
    assign busy_o       = (r_state != StIdle);
    assign err_o        = r_err;
    assign core_start_o = w_launch;
    assign data_valid_o = r_data_valid;
    assign data_o       = r_data;

endmodule

// File: tb/tb_ascon_blk_feeder.sv
// Self-checking bench for ascon_blk_feeder: queue-based reference model compared every cycle,
// plus directed literal expectations for each scenario.
module tb_ascon_blk_feeder;

    localparam int unsigned DW    = 64;
    localparam int unsigned IND   = 4;
    localparam int unsigned CTD   = 4;
    localparam int unsigned TW    = 128;

    localparam logic [DW-1:0] A0 = 64'h1111_1111_1111_1111;
    localparam logic [DW-1:0] P0 = 64'h2222_2222_2222_2222;
    localparam logic [DW-1:0] B0 = 64'h3333_3333_3333_3333;
    localparam logic [DW-1:0] C0 = 64'h4444_4444_4444_4444;
    localparam logic [DW-1:0] E0 = 64'h5555_5555_5555_5555;
    localparam logic [DW-1:0] CT_BASE = 64'hC000_0000_0000_0000;
    localparam logic [DW-1:0] D_BASE  = 64'hD000_0000_0000_0000;
    localparam logic [TW-1:0] T1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [TW-1:0] T2 = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          go_i = 1'b0;
    logic          blk_wr_i = 1'b0;
    logic [DW-1:0] blk_data_i = '0;
    logic          in_full_o;
    logic          ct_rd_i = 1'b0;
    logic [DW-1:0] ct_data_o;
    logic          ct_empty_o;
    logic [TW-1:0] tag_o;
    logic          tag_ok_o;
    logic          busy_o;
    logic [2:0]    err_o;
    logic          core_ready_i = 1'b0;
    logic          core_start_o;
    logic          data_req_i = 1'b0;
    logic          data_valid_o;
    logic [DW-1:0] data_o;
    logic          ct_valid_i = 1'b0;
    logic [DW-1:0] ct_i = '0;
    logic          tag_valid_i = 1'b0;
    logic [TW-1:0] tag_i = '0;
    logic          done_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    ascon_blk_feeder #(
        .DATA_W   (DW),
        .IN_DEPTH (IND),
        .CT_DEPTH (CTD),
        .TAG_W    (TW)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .go_i         (go_i),
        .blk_wr_i     (blk_wr_i),
        .blk_data_i   (blk_data_i),
        .in_full_o    (in_full_o),
        .ct_rd_i      (ct_rd_i),
        .ct_data_o    (ct_data_o),
        .ct_empty_o   (ct_empty_o),
        .tag_o        (tag_o),
        .tag_ok_o     (tag_ok_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .core_ready_i (core_ready_i),
        .core_start_o (core_start_o),
        .data_req_i   (data_req_i),
        .data_valid_o (data_valid_o),
        .data_o       (data_o),
        .ct_valid_i   (ct_valid_i),
        .ct_i         (ct_i),
        .tag_valid_i  (tag_valid_i),
        .tag_i        (tag_i),
        .done_i       (done_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what the outputs must be after each edge.
    logic [DW-1:0] m_inq [$];
    logic [DW-1:0] m_ctq [$];
    bit            m_busy, m_launch, m_pending, m_dv, m_tag_ok;
    logic [2:0]    m_err;
    logic [DW-1:0] m_data;
    logic [TW-1:0] m_tag;

    always @(posedge clk_i or negedge rst_n_i) begin
        bit popped;
        bit was_launch;
        int in_sz;
        int ct_sz;
        if (!rst_n_i) begin
            m_inq.delete();
            m_ctq.delete();
            m_busy = 0; m_launch = 0; m_pending = 0; m_dv = 0; m_tag_ok = 0;
            m_err = '0; m_data = '0; m_tag = '0;
        end else begin
            popped     = 0;
            was_launch = m_launch;
            in_sz      = m_inq.size();
            ct_sz      = m_ctq.size();
            m_dv       = 0;
            if (was_launch) begin
                m_launch = 0;
            end else if (m_busy) begin
                if (m_pending) begin
                    if (data_req_i) m_err[1] = 1'b1;
                    if (in_sz > 0) begin
                        popped    = 1;
                        m_pending = 0;
                    end
                end else if (data_req_i) begin
                    if (in_sz > 0) popped = 1;
                    else           m_pending = 1;
                end else if (done_i && (m_tag_ok || tag_valid_i)) begin
                    m_busy = 0;
                end
            end else if (go_i && core_ready_i) begin
                m_busy   = 1;
                m_launch = 1;
            end
            if (popped) begin
                m_data = m_inq.pop_front();
                m_dv   = 1;
            end
            if (blk_wr_i) begin
                if (in_sz < IND || popped) m_inq.push_back(blk_data_i);
                else                       m_err[0] = 1'b1;
            end
            if (was_launch) begin
                m_err    = '0;
                m_tag    = '0;
                m_tag_ok = 0;
                m_ctq.delete();
            end else begin
                if (ct_rd_i && ct_sz > 0) void'(m_ctq.pop_front());
                if (ct_valid_i) begin
                    if (ct_sz < CTD || ct_rd_i) m_ctq.push_back(ct_i);
                    else                        m_err[2] = 1'b1;
                end
                if (tag_valid_i) begin
                    m_tag    = tag_i;
                    m_tag_ok = 1;
                end
            end
        end
    end

    // Compare DUT outputs to the model mid-cycle.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("m_data_valid", 128'(data_valid_o), 128'(m_dv));
            check("m_data", 128'(data_o), 128'(m_data));
            check("m_core_start", 128'(core_start_o), 128'(m_launch));
            check("m_busy", 128'(busy_o), 128'(m_busy));
            check("m_in_full", 128'(in_full_o), 128'(m_inq.size() == IND));
            check("m_ct_empty", 128'(ct_empty_o), 128'(m_ctq.size() == 0));
            if (m_ctq.size() > 0) check("m_ct_head", 128'(ct_data_o), 128'(m_ctq[0]));
            check("m_err", 128'(err_o), 128'(m_err));
            check("m_tag_ok", 128'(tag_ok_o), 128'(m_tag_ok));
            check("m_tag", tag_o, m_tag);
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic req_once();
        data_req_i = 1'b1;
        cyc();
        data_req_i = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        rst_n_i = 1'b1;
        chk_en  = 1'b1;
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_err", 128'(err_o), 128'(0));
        check("rst_data", 128'(data_o), 128'(0));
        check("rst_ct_empty", 128'(ct_empty_o), 128'(1));
        check("rst_in_full", 128'(in_full_o), 128'(0));
        core_ready_i = 1'b1;

        // Preload two blocks then launch.
        blk_wr_i = 1'b1; blk_data_i = A0; cyc();
        blk_data_i = P0; cyc();
        blk_wr_i = 1'b0;
        go_i = 1'b1; cyc(); go_i = 1'b0;
        check("launch_start", 128'(core_start_o), 128'(1));
        check("launch_busy", 128'(busy_o), 128'(1));
        cyc();
        check("start_once", 128'(core_start_o), 128'(0));
        req_once();
        check("a0_valid", 128'(data_valid_o), 128'(1));
        check("a0_data", 128'(data_o), 128'(A0));
        cyc();
        check("a0_valid_drop", 128'(data_valid_o), 128'(0));
        check("a0_held", 128'(data_o), 128'(A0));
        req_once();
        check("p0_valid", 128'(data_valid_o), 128'(1));
        check("p0_data", 128'(data_o), 128'(P0));

        // Request on empty FIFO, block written five cycles later.
        req_once();
        check("stall_valid", 128'(data_valid_o), 128'(0));
        repeat (4) cyc();
        blk_wr_i = 1'b1; blk_data_i = B0; cyc(); blk_wr_i = 1'b0;
        check("no_bypass", 128'(data_valid_o), 128'(0));
        cyc();
        check("b0_valid", 128'(data_valid_o), 128'(1));
        check("b0_data", 128'(data_o), 128'(B0));
        cyc();
        check("b0_once", 128'(data_valid_o), 128'(0));

        // Second request while one is outstanding.
        data_req_i = 1'b1; cyc(); cyc(); data_req_i = 1'b0;
        check("req_err", 128'(err_o), 128'(3'b010));
        blk_wr_i = 1'b1; blk_data_i = C0; cyc(); blk_wr_i = 1'b0;
        cyc();
        check("c0_data", 128'(data_o), 128'(C0));
        cyc();
        check("c0_once", 128'(data_valid_o), 128'(0));

        tag_valid_i = 1'b1; tag_i = T1; cyc(); tag_valid_i = 1'b0;
        check("tag_val", tag_o, T1);
        check("tag_ok", 128'(tag_ok_o), 128'(1));

        // Ciphertext overflow: five pushes into four entries.
        for (int i = 0; i < 5; i++) begin
            ct_valid_i = 1'b1; ct_i = CT_BASE + 64'(i); cyc();
        end
        ct_valid_i = 1'b0;
        check("ct_ovf_err", 128'(err_o), 128'(3'b110));
        for (int i = 0; i < 4; i++) begin
            check("ct_order", 128'(ct_data_o), 128'(CT_BASE + 64'(i)));
            ct_rd_i = 1'b1; cyc(); ct_rd_i = 1'b0;
        end
        check("ct_drained", 128'(ct_empty_o), 128'(1));
        ct_rd_i = 1'b1; cyc(); ct_rd_i = 1'b0;
        check("ct_pop_empty", 128'(ct_empty_o), 128'(1));

        // Input overflow, then push+pop while full.
        for (int i = 0; i < 5; i++) begin
            blk_wr_i = 1'b1; blk_data_i = D_BASE + 64'(i); cyc();
        end
        blk_wr_i = 1'b0;
        check("in_full", 128'(in_full_o), 128'(1));
        check("in_ovf_err", 128'(err_o), 128'(3'b111));
        blk_wr_i = 1'b1; blk_data_i = D_BASE + 64'd5; data_req_i = 1'b1; cyc();
        blk_wr_i = 1'b0; data_req_i = 1'b0;
        check("full_pushpop", 128'(in_full_o), 128'(1));
        check("d0_data", 128'(data_o), 128'(D_BASE));
        done_i = 1'b1; cyc(); done_i = 1'b0;
        check("done_idle", 128'(busy_o), 128'(0));

        // New run, consume two blocks, then reset with two still queued.
        go_i = 1'b1; cyc(); go_i = 1'b0;
        cyc();
        check("relaunch_err", 128'(err_o), 128'(0));
        check("relaunch_tag_ok", 128'(tag_ok_o), 128'(0));
        req_once();
        check("d1_data", 128'(data_o), 128'(D_BASE + 64'd1));
        ct_valid_i = 1'b1; ct_i = CT_BASE + 64'd9; data_req_i = 1'b1; cyc();
        ct_valid_i = 1'b0; data_req_i = 1'b0;
        check("d2_data", 128'(data_o), 128'(D_BASE + 64'd2));
        #1 rst_n_i = 1'b0;
        #1;
        check("arst_busy", 128'(busy_o), 128'(0));
        check("arst_data", 128'(data_o), 128'(0));
        check("arst_in_full", 128'(in_full_o), 128'(0));
        check("arst_ct_empty", 128'(ct_empty_o), 128'(1));
        check("arst_valid", 128'(data_valid_o), 128'(0));
        cyc();
        rst_n_i = 1'b1;
        go_i = 1'b1; cyc(); go_i = 1'b0;
        check("post_rst_start", 128'(core_start_o), 128'(1));
        cyc();
        req_once();
        check("post_rst_empty", 128'(data_valid_o), 128'(0));
        blk_wr_i = 1'b1; blk_data_i = E0; cyc(); blk_wr_i = 1'b0;
        cyc();
        check("e0_data", 128'(data_o), 128'(E0));
        tag_valid_i = 1'b1; tag_i = T2; cyc(); tag_valid_i = 1'b0;
        done_i = 1'b1; cyc(); done_i = 1'b0;
        check("final_idle", 128'(busy_o), 128'(0));
        check("final_tag", tag_o, T2);
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
